// File: rtl/ex_mdu_pkg.sv
// Shared decode constants for the RV32M multiply/divide unit: opcode/funct7 match,
// funct3 operation codes and MDU state encodings.
package ex_mdu_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  function automatic logic is_m_inst(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider datapath: loads dividend/divisor, then produces one
// quotient bit per enabled cycle; quotient and remainder are valid after XLEN steps.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_div;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // Dividend bits shift out of r_quot's MSB while quotient bits enter at its LSB.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
    end else if (i_en) begin
      if (!w_diff[XLEN]) begin
        r_rem  <= w_diff[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b0};
      end
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide execute unit with one-cycle write-back and pipeline hold.
// Optional MDU_FAST_MUL_EN: single-cycle multiplier registered at acceptance.
module ex_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [31:0]     inst_i,
  input  logic            reg_wen_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic            hold_flag_o,
  output logic            busy_o
);

  import ex_mdu_pkg::*;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic              r_neg;
  logic              r_short;
  logic [XLEN-1:0]   r_short_res;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;

  logic [2:0]        w_f3;
  logic              w_is_m, w_accept, w_is_div;
  logic              w_sgn1, w_sgn2, w_neg1, w_neg2, w_res_neg;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_short_res;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_quot, w_rem;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quot_s, w_rem_s, w_result;
  logic              w_done;
  logic              w_unused_inst;

  assign w_unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  assign w_f3     = inst_i[14:12];
  assign w_is_m   = is_m_inst(inst_i[6:0], inst_i[31:25]);
  assign w_accept = (r_state == MDU_IDLE) && w_is_m && !flush_i;
  assign w_is_div = w_f3[2];

  assign w_sgn1    = (w_f3 == INST_MULH) || (w_f3 == INST_MULHSU) ||
                     (w_f3 == INST_DIV)  || (w_f3 == INST_REM);
  assign w_sgn2    = (w_f3 == INST_MULH) || (w_f3 == INST_DIV) || (w_f3 == INST_REM);
  assign w_neg1    = w_sgn1 && op1_i[XLEN-1];
  assign w_neg2    = w_sgn2 && op2_i[XLEN-1];
  assign w_mag1    = w_neg1 ? -op1_i : op1_i;
  assign w_mag2    = w_neg2 ? -op2_i : op2_i;
  assign w_res_neg = (w_f3 == INST_REM) ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div0 = w_is_div && (op2_i == '0);
  assign w_ovf  = ((w_f3 == INST_DIV) || (w_f3 == INST_REM)) &&
                  (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  // funct3[1] distinguishes REM/REMU from DIV/DIVU among the divide codes.
  assign w_short_res = w_div0 ? (w_f3[1] ? op1_i : '1) : (w_f3[1] ? '0 : op1_i);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast       = !w_is_div;
  assign w_fast_prod  = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
`else
  assign w_fast = 1'b0;
`endif

  assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && w_is_div),
    .i_en       ((r_state == MDU_BUSY) && r_f3[2]),
    .i_dividend (w_mag1),
    .i_divisor  (w_mag2),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MDU_IDLE;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_rd        <= '0;
      r_wen       <= 1'b0;
      r_neg       <= 1'b0;
      r_short     <= 1'b0;
      r_short_res <= '0;
      r_prod      <= '0;
      r_mcand     <= '0;
    end else if (flush_i) begin
      r_state <= MDU_IDLE;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_f3        <= w_f3;
            r_rd        <= rd_addr_i;
            r_wen       <= reg_wen_i;
            r_neg       <= w_res_neg;
            r_short     <= w_div0 || w_ovf;
            r_short_res <= w_short_res;
            r_cnt       <= '0;
            if (!w_is_div) begin
              r_mcand <= w_mag1;
`ifdef MDU_FAST_MUL_EN
              r_prod  <= w_fast_prod;
`else
              r_prod  <= {{XLEN{1'b0}}, w_mag2};
`endif
            end
            r_state <= (w_div0 || w_ovf || w_fast) ? MDU_DONE : MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          // Shift-add: partial sum enters the upper half as the multiplier drains from the lower.
          if (!r_f3[2]) r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
          if (r_cnt == CNT_W'(XLEN - 1)) r_state <= MDU_DONE;
          else                           r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign w_prod_s = r_neg ? -r_prod : r_prod;
  assign w_quot_s = r_neg ? -w_quot : w_quot;
  assign w_rem_s  = r_neg ? -w_rem  : w_rem;

  always_comb begin
    w_result = '0;
    if (r_short)             w_result = r_short_res;
    else if (r_f3[2])        w_result = r_f3[1] ? w_rem_s : w_quot_s;
    else if (r_f3 == INST_MUL) w_result = w_prod_s[XLEN-1:0];
    else                     w_result = w_prod_s[2*XLEN-1:XLEN];
  end

  assign w_done      = (r_state == MDU_DONE) && !flush_i;
  assign rd_data_o   = w_done ? w_result : '0;
  assign rd_addr_o   = w_done ? r_rd : '0;
  assign reg_wen_o   = w_done && r_wen;
  assign hold_flag_o = !flush_i && (((r_state == MDU_IDLE) && w_is_m) || (r_state == MDU_BUSY));
  assign busy_o      = (r_state != MDU_IDLE);

endmodule
